// File: rtl/radix4_serial_add_seq.sv
// radix4_serial_add_seq
// Sequencer around an external combinational 2-bit adder stage. A WIDTH-bit
// add request is split into WIDTH/2 slices that are fed to the adder LSB
// slice first, one slice per clock. Each slice's carry-out becomes the next
// slice's carry-in. The returned 2-bit sums are collected into the result.
module radix4_serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [1:0]       add_a,
  output logic [1:0]       add_b,
  output logic             add_cin,
  input  logic [1:0]       add_sum,
  input  logic             add_cout
);

  localparam int NSLICE = WIDTH / 2;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Odd widths cannot be split into 2-bit slices, so stop at elaboration.
  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $fatal(1, "radix4_serial_add_seq: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q;
  logic [WIDTH-1:0]   sh_a_q;
  logic [WIDTH-1:0]   sh_b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               last_slice;

  assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));

  // Adder-facing slice outputs: live only while slices are being processed.
  assign add_a   = (state_q == RUN) ? sh_a_q[1:0] : 2'b00;
  assign add_b   = (state_q == RUN) ? sh_b_q[1:0] : 2'b00;
  assign add_cin = (state_q == RUN) ? carry_q     : 1'b0;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

  // Sequencer FSM: operand capture, per-slice carry threading, result assembly.
  // NOTE: every register in this block uses <= so all of them update from the
  // pre-edge values; a blocking = here would let cnt_q/carry_q race ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // done is a one-cycle pulse unless the last slice sets it below.
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          // A start in DONE is accepted exactly like one in IDLE (back-to-back).
          if (start) begin
            sh_a_q   <= op_a;
            sh_b_q   <= op_b;
            carry_q  <= cin;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately ignored here; operands are already captured.
          result_q[{cnt_q, 1'b0} +: 2] <= add_sum;
          carry_q <= add_cout;
          sh_a_q  <= sh_a_q >> 2;
          sh_b_q  <= sh_b_q >> 2;
          cnt_q   <= cnt_q + 1'b1;
          if (last_slice) begin
            cout_q  <= add_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_serial_add_seq.sv
// Bench for radix4_serial_add_seq: an 8-bit instance driven from a vector
// table and hand-written corner sequences, plus a 2-bit instance. Each DUT
// talks to a behavioural 2-bit adder. Expected results are queued when a
// start is driven and compared when done pulses.
module tb_radix4_serial_add_seq;

  logic clk;
  logic rst;

  // 8-bit instance
  logic       start8;
  logic [7:0] op_a8, op_b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] result8;
  logic [1:0] add_a8, add_b8, add_sum8;
  logic       add_cin8, add_cout8;

  // 2-bit instance
  logic       start2;
  logic [1:0] op_a2, op_b2;
  logic       cin2;
  logic       busy2, done2, cout2;
  logic [1:0] result2;
  logic [1:0] add_a2, add_b2, add_sum2;
  logic       add_cin2, add_cout2;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       co;
    logic       chk_seq;
    logic [7:0] a_seq;
    logic [3:0] cin_seq;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       co;
  } exp_t;

  exp_t sb_q[$];
  vec_t vec[14];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt8 = 0;

  radix4_serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op_a(op_a8), .op_b(op_b8),
    .cin(cin8), .busy(busy8), .done(done8), .result(result8), .cout(cout8),
    .add_a(add_a8), .add_b(add_b8), .add_cin(add_cin8),
    .add_sum(add_sum8), .add_cout(add_cout8)
  );

  radix4_serial_add_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_a(op_a2), .op_b(op_b2),
    .cin(cin2), .busy(busy2), .done(done2), .result(result2), .cout(cout2),
    .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
    .add_sum(add_sum2), .add_cout(add_cout2)
  );

  // Behavioural 2-bit ripple adders standing in for the real stage.
  assign {add_cout8, add_sum8} = add_a8 + add_b8 + add_cin8;
  assign {add_cout2, add_sum2} = add_a2 + add_b2 + add_cin2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      done_cnt8++;
      check("sb_expected_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result", 32'(result8), 32'(e.res));
        check("sb_cout", 32'(cout8), 32'(e.co));
      end
    end
  end

  // Waits for done8, deasserting start on every negedge. n counts negedges
  // from the call; gaps counts non-done cycles where busy was low.
  task automatic wait_done(input int max_n, output int n, output int gaps,
                           output logic [7:0] a_seq, output logic [3:0] cin_seq);
    n = 0;
    gaps = 0;
    a_seq = '0;
    cin_seq = '0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      n++;
      if (done8 !== 1'b1) begin
        if (busy8 !== 1'b1) gaps++;
        if (n <= 4) begin
          a_seq[2*(n-1) +: 2] = add_a8;
          cin_seq[n-1] = add_cin8;
        end
      end
    end while ((done8 !== 1'b1) && (n < max_n));
    check("done_seen", 32'(done8), 32'd1);
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] r, input logic co);
    exp_t e;
    start8 = 1'b1;
    op_a8 = a;
    op_b8 = b;
    cin8 = c;
    e.res = r;
    e.co = co;
    sb_q.push_back(e);
  endtask

  initial begin
    int n, gaps, d0;
    logic [7:0] a_seq;
    logic [3:0] cin_seq;
    logic [8:0] s;

    rst = 1'b0;
    start8 = 1'b0; op_a8 = '0; op_b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; op_a2 = '0; op_b2 = '0; cin2 = 1'b0;

    vec[0] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1, 8'h5A, 4'b1011};
    vec[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 4'b1110};
    vec[2] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 4'b0000};
    vec[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000};
    vec[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 4'b0000};
    vec[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0000};
    vec[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 4'b0000};
    vec[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0000};
    vec[8] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 8'h00, 4'b0000};
    vec[9] = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0000};
    for (int i = 10; i < 14; i++) begin
      vec[i].a = 8'($urandom);
      vec[i].b = 8'($urandom);
      vec[i].cin = 1'($urandom);
      s = {1'b0, vec[i].a} + {1'b0, vec[i].b} + {8'd0, vec[i].cin};
      vec[i].res = s[7:0];
      vec[i].co = s[8];
      vec[i].chk_seq = 1'b0;
      vec[i].a_seq = '0;
      vec[i].cin_seq = '0;
    end

    // Asynchronous reset with no clock edge needed.
    #1 rst = 1'b1;
    #2;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_result", 32'(result8), 32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    check("rst_add_a", 32'(add_a8), 32'd0);
    check("rst_add_b", 32'(add_b8), 32'd0);
    check("rst_add_cin", 32'(add_cin8), 32'd0);
    check("rst_result2", 32'(result2), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy8), 32'd0);

    // Table-driven operations.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive8(vec[i].a, vec[i].b, vec[i].cin, vec[i].res, vec[i].co);
      wait_done(20, n, gaps, a_seq, cin_seq);
      check("latency", 32'(n), 32'd5);
      check("busy_during_run", 32'(gaps), 32'd0);
      check("busy_low_at_done", 32'(busy8), 32'd0);
      if (vec[i].chk_seq) begin
        check("add_a_seq", 32'(a_seq), 32'(vec[i].a_seq));
        check("add_cin_seq", 32'(cin_seq), 32'(vec[i].cin_seq));
      end
      @(negedge clk);
      check("done_single_pulse", 32'(done8), 32'd0);
      check("result_held", 32'(result8), 32'(vec[i].res));
      check("cout_held", 32'(cout8), 32'(vec[i].co));
    end

    // start during the 2nd RUN cycle is ignored.
    d0 = done_cnt8;
    @(negedge clk);
    drive8(8'h21, 8'h10, 1'b0, 8'h31, 1'b0);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    op_a8 = 8'h11;
    wait_done(20, n, gaps, a_seq, cin_seq);
    check("ignored_start_latency", 32'(n), 32'd3);
    repeat (8) @(negedge clk);
    check("ignored_start_one_done", 32'(done_cnt8 - d0), 32'd1);
    check("ignored_start_idle", 32'(busy8), 32'd0);

    // Back-to-back: start held during the DONE cycle.
    d0 = done_cnt8;
    @(negedge clk);
    drive8(8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0);
    wait_done(20, n, gaps, a_seq, cin_seq);
    check("b2b_first_latency", 32'(n), 32'd5);
    check("b2b_first_busy_low", 32'(busy8), 32'd0);
    drive8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
    wait_done(20, n, gaps, a_seq, cin_seq);
    check("b2b_second_latency", 32'(n), 32'd5);
    check("b2b_busy_gaps", 32'(gaps), 32'd0);
    check("b2b_busy_low_at_done", 32'(busy8), 32'd0);
    @(negedge clk);
    check("b2b_done_count", 32'(done_cnt8 - d0), 32'd2);

    // Asynchronous reset in the 3rd RUN cycle abandons the operation.
    d0 = done_cnt8;
    @(negedge clk);
    start8 = 1'b1;
    op_a8 = 8'h5A;
    op_b8 = 8'h33;
    cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_busy", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(busy8), 32'd0);
    check("midrun_rst_done", 32'(done8), 32'd0);
    check("midrun_rst_result", 32'(result8), 32'd0);
    check("midrun_rst_cout", 32'(cout8), 32'd0);
    check("midrun_rst_add", 32'({add_a8, add_b8, add_cin8}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrun_no_done", 32'(done_cnt8 - d0), 32'd0);
    drive8(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0);
    wait_done(20, n, gaps, a_seq, cin_seq);
    check("after_rst_latency", 32'(n), 32'd5);

    // WIDTH=2 instance: a single slice.
    @(negedge clk);
    start2 = 1'b1;
    op_a2 = 2'd3;
    op_b2 = 2'd3;
    cin2 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start2 = 1'b0;
      n++;
    end while ((done2 !== 1'b1) && (n < 10));
    check("w2_latency", 32'(n), 32'd2);
    check("w2_done", 32'(done2), 32'd1);
    check("w2_result", 32'(result2), 32'd3);
    check("w2_cout", 32'(cout2), 32'd1);
    @(negedge clk);
    check("w2_done_pulse", 32'(done2), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
